// File: rtl/dram_arbiter.sv
// Four-requester DRAM burst arbiter: one winner per transaction, four fixed beats, then a release cycle.
// Define DRAM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 always has highest priority.
module dram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  req_we,
    input  logic [63:0] req_addr,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy,
    output logic [3:0]  en,
    output logic [7:0]  dram_address,
    output logic        dram_we
);

    typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, BEAT3, BEAT4, REL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  stride_q, stride_d;
    logic        we_q, we_d;
    logic [1:0]  pick;
    logic [15:0] slice;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest requester at/after the pointer wins.
    always_comb begin
        pick = ptr_q;
        idx  = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) pick = idx;
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) pick = 2'(i);
        end
    end
`endif

    assign slice = req_addr[{pick, 4'b0000} +: 16];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        we_d     = we_q;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = BEAT1;
                    winner_d = pick;
                    addr_d   = slice[15:8];
                    // A zero stride makes the beats repeat the base row for non-stepping loads.
                    stride_d = (slice[7] | req_we[pick]) ? {1'b0, slice[6:0]} : 8'h00;
                    we_d     = req_we[pick];
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                    ptr_d    = pick + 2'd1;
`endif
                end
            end
            BEAT1: begin state_d = BEAT2; addr_d = addr_q + stride_q; end
            BEAT2: begin state_d = BEAT3; addr_d = addr_q + stride_q; end
            BEAT3: begin state_d = BEAT4; addr_d = addr_q + stride_q; end
            BEAT4: state_d = REL;
            REL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    // NOTE: the address register is reset too, since dram_address must read 8'h00 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            we_q     <= 1'b0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            we_q     <= we_d;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        en      = '0;
        dram_we = 1'b0;
        case (state_q)
            BEAT1: begin en = 4'b0001; gnt = 4'b0001 << winner_q; dram_we = we_q; end
            BEAT2: begin en = 4'b0010; gnt = 4'b0001 << winner_q; dram_we = we_q; end
            BEAT3: begin en = 4'b0100; gnt = 4'b0001 << winner_q; dram_we = we_q; end
            BEAT4: begin en = 4'b1000; gnt = 4'b0001 << winner_q; dram_we = we_q; end
            REL:   done = 4'b0001 << winner_q;
            default: ;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign dram_address = addr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter; expectations follow the macro setting of the build.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [63:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  en;
    logic [7:0]  dram_address;
    logic        dram_we;

    int n_checks = 0;
    int n_fail   = 0;

    dram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .done         (done),
        .busy         (busy),
        .en           (en),
        .dram_address (dram_address),
        .dram_we      (dram_we)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs a burst starting from IDLE with req already driven; ends in REL.
    task automatic run_burst(input string tag, input logic [3:0] g, input logic w, input logic [31:0] addrs);
        logic [3:0] en_exp;
        for (int k = 0; k < 4; k++) begin
            step();
            en_exp = 4'b0001 << k;
            check({tag, " en"},   en, en_exp);
            check({tag, " gnt"},  gnt, g);
            check({tag, " we"},   dram_we, w);
            check({tag, " addr"}, dram_address, addrs[31-8*k -: 8]);
            check({tag, " done"}, done, 4'b0000);
            check({tag, " busy"}, busy, 1'b1);
        end
        step();
        check({tag, " rel done"}, done, g);
        check({tag, " rel gnt"},  gnt, 4'b0000);
        check({tag, " rel en"},   en, 4'b0000);
        check({tag, " rel we"},   dram_we, 1'b0);
        check({tag, " rel addr"}, dram_address, addrs[7:0]);
    endtask

    logic [31:0] beat_tbl [4];
    int          order [5];

    initial begin
        beat_tbl = '{32'h2024282C, 32'h40404040, 32'hF8081828, 32'h10131619};
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        rst      = 1'b1;
        req      = '0;
        req_we   = '0;
        req_addr = {16'h1083, 16'hF810, 16'h4005, 16'h2084};
        step();
        step();
        check("rst gnt",  gnt, 4'b0000);
        check("rst done", done, 4'b0000);
        check("rst en",   en, 4'b0000);
        check("rst busy", busy, 1'b0);
        check("rst we",   dram_we, 1'b0);
        check("rst addr", dram_address, 8'h00);
        rst = 1'b0;
        step();
        check("idle busy", busy, 1'b0);

        // Single stepped load for requester 0
        req = 4'b0001;
        run_burst("load0", 4'b0001, 1'b0, 32'h2024282C);
        req = 4'b0000;
        step();
        check("load0 idle busy", busy, 1'b0);
        check("load0 idle done", done, 4'b0000);
        check("load0 hold addr", dram_address, 8'h2C);
        step();
        check("load0 no regrant", busy, 1'b0);

        // Non-stepping load for requester 1
        req = 4'b0010;
        run_burst("load1", 4'b0010, 1'b0, 32'h40404040);
        req = 4'b0000;
        step();
        check("load1 idle busy", busy, 1'b0);

        // Store with 8-bit wrap for requester 2
        req    = 4'b0100;
        req_we = 4'b0100;
        run_burst("store2", 4'b0100, 1'b1, 32'hF8081828);
        req = 4'b0000;
        step();
        check("store2 idle we", dram_we, 1'b0);

        // Contention from a freshly reset pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_burst($sformatf("cont%0d", n), 4'b0001 << order[n], (order[n] == 2),
                      beat_tbl[order[n]]);
            step();
            check($sformatf("cont%0d idle", n), busy, 1'b0);
        end

        // Reset in BEAT2 of a requester-3 burst
        req    = 4'b1000;
        req_we = 4'b0000;
        step();
        check("rst3 b1 gnt",  gnt, 4'b1000);
        check("rst3 b1 addr", dram_address, 8'h10);
        step();
        check("rst3 b2 en",   en, 4'b0010);
        check("rst3 b2 addr", dram_address, 8'h13);
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        check("rst3 busy", busy, 1'b0);
        check("rst3 en",   en, 4'b0000);
        check("rst3 gnt",  gnt, 4'b0000);
        check("rst3 done", done, 4'b0000);
        check("rst3 addr", dram_address, 8'h00);
        for (int n = 0; n < 4; n++) begin
            step();
            check("rst3 no done", done, 4'b0000);
            check("rst3 no en", en, 4'b0000);
        end
        req = 4'b0001;
        run_burst("post rst", 4'b0001, 1'b0, 32'h2024282C);
        req = 4'b0000;
        step();
        check("post rst idle", busy, 1'b0);

        // Withdrawal mid-burst with address/we changes
        req = 4'b0001;
        step();
        check("wd b1 addr", dram_address, 8'h20);
        step();
        check("wd b2 addr", dram_address, 8'h24);
        req             = 4'b0000;
        req_addr[15:0]  = 16'h5001;
        req_we          = 4'b0001;
        step();
        check("wd b3 addr", dram_address, 8'h28);
        check("wd b3 we",   dram_we, 1'b0);
        check("wd b3 gnt",  gnt, 4'b0001);
        step();
        check("wd b4 addr", dram_address, 8'h2C);
        check("wd b4 en",   en, 4'b1000);
        step();
        check("wd rel done", done, 4'b0001);
        step();
        check("wd idle busy", busy, 1'b0);
        step();
        check("wd no regrant busy", busy, 1'b0);
        check("wd no regrant gnt",  gnt, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
